// File: rtl/mem_port_if.sv
// Memory bus between the multicycle port (master) and the memory model or
// fabric (slave). Valid/ack handshake with variable latency.
interface mem_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_port.sv
// Multicycle memory port: runs fetch/load/store phases for the control FSM,
// holding the instruction register and memory data register, with a watchdog.
//
// state | meaning
// IDLE  | waiting for IRWrite or IorD from the controller
// REQ   | bus cycle in flight, waiting for bus_ack or watchdog expiry
// DONE  | access finished, controller released; no new access this cycle
module mem_port #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IRWrite,
  input  logic              IorD,
  input  logic              MemWE,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm16,
  output logic [25:0]       target,
  output logic [DATA_W-1:0] mdr,
  output logic              addr_err,
  output logic              bus_err,
  mem_port_if.master        bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef enum logic [1:0] {DST_NONE, DST_IR, DST_MDR} dest_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  dest_t             dest;
  logic [7:0]        wdog;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              pending;
  logic [ADDR_W-1:0] acc_addr;

  assign pending  = (IRWrite | IorD) && (state == IDLE);
  // Fetch wins when both requests are raised together.
  assign acc_addr = IRWrite ? pc : alu_addr;
  assign stall    = pending || (state == REQ);

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];
  assign target = instr[25:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      dest     <= DST_NONE;
      wdog     <= 8'd0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      instr    <= 32'd0;
      mdr      <= '0;
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            if (IRWrite)    dest <= DST_IR;
            else if (MemWE) dest <= DST_NONE;
            else            dest <= DST_MDR;
            if (acc_addr[1:0] != 2'b00) begin
              addr_err <= 1'b1;
              state    <= DONE;
            end else begin
              req_q   <= 1'b1;
              we_q    <= MemWE & ~IRWrite;
              addr_q  <= acc_addr;
              wdata_q <= wdata;
              wdog    <= 8'd0;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          // An ack in the last watchdog cycle still counts as success.
          if (bus.bus_ack) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            case (dest)
              DST_IR:  instr <= 32'(bus.bus_rdata);
              DST_MDR: mdr   <= bus.bus_rdata;
              default: ;
            endcase
            state <= DONE;
          end else if (wdog == WDOG_LAST) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            bus_err <= 1'b1;
            state   <= DONE;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port: fetch, load, store, misaligned, watchdog and
// reset-during-access, checked cycle by cycle against hand-computed values.
module tb_mem_port;
  logic        clk = 1'b0;
  logic        reset;
  logic        IRWrite, IorD, MemWE;
  logic [31:0] pc, alu_addr, wdata;
  logic        stall;
  logic [31:0] instr, mdr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [25:0] target;
  logic        addr_err, bus_err;

  int checks = 0;
  int errors = 0;

  mem_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .IRWrite(IRWrite), .IorD(IorD), .MemWE(MemWE),
    .pc(pc), .alu_addr(alu_addr), .wdata(wdata), .stall(stall),
    .instr(instr), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .imm16(imm16), .target(target), .mdr(mdr),
    .addr_err(addr_err), .bus_err(bus_err), .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; IRWrite = 1'b0; IorD = 1'b0; MemWE = 1'b0;
    pc = '0; alu_addr = '0; wdata = '0;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    step(); step();
    chk("rst_req",   32'(bus.bus_req), 32'd0);
    chk("rst_we",    32'(bus.bus_we), 32'd0);
    chk("rst_addr",  bus.bus_addr, 32'd0);
    chk("rst_wdata", bus.bus_wdata, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_mdr",   mdr, 32'd0);
    chk("rst_errs",  {30'd0, addr_err, bus_err}, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    step();

    // Fetch, zero wait states
    IRWrite = 1'b1; pc = 32'h0000_0040; #1;
    chk("f_c0_stall", 32'(stall), 32'd1);
    chk("f_c0_req",   32'(bus.bus_req), 32'd0);
    step();
    chk("f_c1_req",   32'(bus.bus_req), 32'd1);
    chk("f_c1_addr",  bus.bus_addr, 32'h40);
    chk("f_c1_stall", 32'(stall), 32'd1);
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h2008_0005;
    step();
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
    chk("f_c2_stall", 32'(stall), 32'd0);
    chk("f_c2_req",   32'(bus.bus_req), 32'd0);
    chk("f_instr",    instr, 32'h2008_0005);
    chk("f_opcode",   32'(opcode), 32'h08);
    chk("f_rs",       32'(rs), 32'd0);
    chk("f_rt",       32'(rt), 32'd8);
    chk("f_rd",       32'(rd), 32'd0);
    chk("f_imm16",    32'(imm16), 32'd5);
    chk("f_funct",    32'(funct), 32'd5);
    chk("f_target",   32'(target), 32'h0080005);
    step();
    chk("f_c3_noreq", 32'(bus.bus_req), 32'd0);
    IRWrite = 1'b0; #1;
    chk("f_c3_stall", 32'(stall), 32'd0);
    step();

    // Load, ack after 3 wait cycles (ack in the last watchdog cycle)
    IorD = 1'b1; MemWE = 1'b0; alu_addr = 32'h100; #1;
    chk("l_c0_stall", 32'(stall), 32'd1);
    step();
    chk("l_c1_req",  32'(bus.bus_req), 32'd1);
    chk("l_c1_we",   32'(bus.bus_we), 32'd0);
    chk("l_c1_addr", bus.bus_addr, 32'h100);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk($sformatf("l_c%0d_req", c), 32'(bus.bus_req), 32'd1);
      chk($sformatf("l_c%0d_stall", c), 32'(stall), 32'd1);
    end
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'hDEAD_BEEF;
    step();
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
    chk("l_c5_stall", 32'(stall), 32'd0);
    chk("l_mdr",      mdr, 32'hDEAD_BEEF);
    chk("l_instr",    instr, 32'h2008_0005);
    chk("l_buserr",   32'(bus_err), 32'd0);
    step();
    IorD = 1'b0;
    step();

    // Store with one wait cycle; wdata input changes after launch
    IorD = 1'b1; MemWE = 1'b1; alu_addr = 32'h104; wdata = 32'h1234_5678;
    step();
    wdata = 32'h0;
    chk("s_c1_we",    32'(bus.bus_we), 32'd1);
    chk("s_c1_addr",  bus.bus_addr, 32'h104);
    chk("s_c1_wdata", bus.bus_wdata, 32'h1234_5678);
    step();
    chk("s_c2_req",   32'(bus.bus_req), 32'd1);
    chk("s_c2_we",    32'(bus.bus_we), 32'd1);
    chk("s_c2_wdata", bus.bus_wdata, 32'h1234_5678);
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'hFFFF_FFFF;
    step();
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
    chk("s_c3_req",   32'(bus.bus_req), 32'd0);
    chk("s_c3_we",    32'(bus.bus_we), 32'd0);
    chk("s_mdr",      mdr, 32'hDEAD_BEEF);
    chk("s_instr",    instr, 32'h2008_0005);
    step();
    IorD = 1'b0; MemWE = 1'b0;
    step();

    // Misaligned load
    IorD = 1'b1; alu_addr = 32'h102; #1;
    chk("m_c0_stall", 32'(stall), 32'd1);
    step();
    chk("m_c1_stall", 32'(stall), 32'd0);
    chk("m_c1_req",   32'(bus.bus_req), 32'd0);
    chk("m_c1_aerr",  32'(addr_err), 32'd1);
    step();
    IorD = 1'b0;
    chk("m_c2_req",   32'(bus.bus_req), 32'd0);
    step();
    chk("m_sticky",   32'(addr_err), 32'd1);
    chk("m_mdr",      mdr, 32'hDEAD_BEEF);

    // Fetch with no ack: watchdog expires after 4 request cycles
    IRWrite = 1'b1; pc = 32'h200;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("t_c%0d_req", c), 32'(bus.bus_req), 32'd1);
      chk($sformatf("t_c%0d_berr", c), 32'(bus_err), 32'd0);
    end
    step();
    chk("t_c5_req",   32'(bus.bus_req), 32'd0);
    chk("t_c5_berr",  32'(bus_err), 32'd1);
    chk("t_c5_stall", 32'(stall), 32'd0);
    chk("t_instr",    instr, 32'h2008_0005);
    step();
    IRWrite = 1'b0;
    step();
    chk("t_sticky",   32'(bus_err), 32'd1);

    // Clear sticky flags, then fetch with ack on the 4th request cycle
    reset = 1'b1;
    step();
    chk("r_errs", {30'd0, addr_err, bus_err}, 32'd0);
    reset = 1'b0;
    step();
    IRWrite = 1'b1; pc = 32'h300;
    for (int c = 1; c <= 3; c++) step();
    chk("a4_c3_req", 32'(bus.bus_req), 32'd1);
    step();
    chk("a4_c4_req", 32'(bus.bus_req), 32'd1);
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h8C09_0010;
    step();
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
    chk("a4_berr",   32'(bus_err), 32'd0);
    chk("a4_instr",  instr, 32'h8C09_0010);
    chk("a4_opcode", 32'(opcode), 32'h23);
    chk("a4_rt",     32'(rt), 32'd9);
    chk("a4_imm16",  32'(imm16), 32'h10);
    step();
    IRWrite = 1'b0;
    step();

    // Reset during REQ, then a late ack
    IorD = 1'b1; MemWE = 1'b0; alu_addr = 32'h108;
    step();
    chk("x_c1_req", 32'(bus.bus_req), 32'd1);
    reset = 1'b1; IorD = 1'b0;
    step();
    chk("x_req",   32'(bus.bus_req), 32'd0);
    chk("x_stall", 32'(stall), 32'd0);
    reset = 1'b0; bus.bus_ack = 1'b1; bus.bus_rdata = 32'h5555_5555;
    step();
    bus.bus_ack = 1'b0;
    chk("x_mdr",    mdr, 32'd0);
    chk("x_instr",  instr, 32'd0);
    chk("x_req2",   32'(bus.bus_req), 32'd0);
    chk("x_stall2", 32'(stall), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
